// File: rtl/tp_sync_sink.sv
// -----------------------------------------------------------------------------
// tp_sync_sink
//   Receives tokens from an asynchronous producer over a two-phase dual-rail
//   link, decodes each token into a WIDTH-bit word and buffers the words in a
//   DEPTH-entry FIFO. Each accepted token is acknowledged with one toggle of
//   ack_o. When the FIFO is full, a complete token is held on the rails (the
//   FSM sits in STALL) until the consumer frees an entry.
//
// Ports
//   clk    : sole clock, rising edge
//   rst    : asynchronous reset, active low
//   in     : dual-rail data, in[i][1] = rail 1 (value 1), in[i][0] = rail 0
//   ack_o  : two-phase acknowledge to the producer
//   dat_o  : FIFO head word, 0 when empty
//   vld_o  : FIFO non-empty
//   rdy_i  : consumer ready; vld_o & rdy_i pops the head
//   level  : FIFO occupancy
// -----------------------------------------------------------------------------
module tp_sync_sink #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [WIDTH-1:0][1:0]       in,
   output logic                        ack_o,
   output logic [WIDTH-1:0]            dat_o,
   output logic                        vld_o,
   input  logic                        rdy_i,
   output logic [$clog2(DEPTH):0]      level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic {WAIT, STALL} state_e;

   // Rail synchronizers: stage 0 samples the asynchronous rails, the last
   // stage is the only copy the rest of the design may look at.
   logic [SYNC_STAGES-1:0][WIDTH-1:0][1:0] sync_q, sync_d;
   logic [WIDTH-1:0] s0, s1;

   state_e           state_q, state_d;
   logic             ph_q, ph_d;
   logic             ack_q, ack_d;
   logic [WIDTH-1:0] r0_q, r0_d;
   logic [WIDTH-1:0] r1_q, r1_d;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    count_q, count_d;

   logic             complete;
   logic             space;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] decoded;

   // ---------------------------------------------------------------------------
   // Synchronizer shift and rail decode
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a value on
      // every path (here unconditionally) so no latch is inferred.
      sync_d = {sync_q[SYNC_STAGES-2:0], in};
      for (int i = 0; i < WIDTH; i++) begin
         s0[i] = sync_q[SYNC_STAGES-1][i][0];
         s1[i] = sync_q[SYNC_STAGES-1][i][1];
      end
   end

   // A token is complete only once every bit has seen exactly one rail toggle
   // relative to the expected phase; a partially arrived token fails this.
   assign complete = ((s1 ^ s0) == {WIDTH{~ph_q}});
   assign decoded  = s1 ^ r1_q;

   assign vld_o = (count_q != '0);
   assign pop   = vld_o & rdy_i;
   // count_q never exceeds DEPTH, so "not full" covers level < DEPTH; a pop
   // in the same cycle frees the slot the push is about to use.
   assign space = (count_q != LW'(DEPTH)) | pop;

   // ---------------------------------------------------------------------------
   // FSM: state register / next state / outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst) state_q <= WAIT;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT:    if (complete && !space) state_d = STALL;
         STALL:   if (space)              state_d = WAIT;
         default: state_d = WAIT;
      endcase
   end

   // In STALL the producer cannot move (no ack yet), so the held token is
   // still complete and only space gates the push.
   always_comb begin
      push = 1'b0;
      case (state_q)
         WAIT:    push = complete & space;
         STALL:   push = space;
         default: push = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Link state and FIFO bookkeeping
   // ---------------------------------------------------------------------------
   always_comb begin
      ph_d     = ph_q ^ push;
      ack_d    = ack_q ^ push;
      r0_d     = push ? s0 : r0_q;
      r1_d     = push ? s1 : r1_q;
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + LW'(push) - LW'(pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q   <= '0;
         ph_q     <= 1'b0;
         ack_q    <= 1'b0;
         r0_q     <= '0;
         r1_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         sync_q   <= sync_d;
         ph_q     <= ph_d;
         ack_q    <= ack_d;
         r0_q     <= r0_d;
         r1_q     <= r1_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; an entry is only
   // ever read after it has been written, and dat_o is forced to 0 when empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= decoded;
   end

   assign dat_o = vld_o ? mem_q[rd_ptr_q] : '0;
   assign ack_o = ack_q;
   assign level = count_q;

endmodule

// File: tb/tb_tp_sync_sink.sv
module tb_tp_sync_sink;

   localparam int W = 4;
   localparam int D = 4;
   localparam int S = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [W-1:0][1:0] rails;
   logic              ack_o;
   logic [W-1:0]      dat_o;
   logic              vld_o;
   logic              rdy_i;
   logic [2:0]        level;

   always #5 clk = ~clk;

   tp_sync_sink #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(S)) dut (
      .clk   (clk),
      .rst   (rst),
      .in    (rails),
      .ack_o (ack_o),
      .dat_o (dat_o),
      .vld_o (vld_o),
      .rdy_i (rdy_i),
      .level (level)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: words the sink has acknowledged but not yet delivered.
   logic [W-1:0] exp_q[$];
   logic [W-1:0] cur_tok     = '0;
   bit           outstanding = 1'b0;  // producer has a fully sent, unacked token
   bit           prod_ph     = 1'b0;  // ack level the producer is waiting for
   bit           mon_en      = 1'b0;
   bit           rand_rdy_en = 1'b0;
   logic         ack_prev    = 1'b0;
   int           ack_cnt     = 0;

   // Scoreboard: every ack toggle enqueues the outstanding word; every
   // vld&rdy cycle must present the oldest enqueued word.
   always @(negedge clk) begin
      if (mon_en) begin
         if (ack_o !== ack_prev) begin
            checks++;
            if (!outstanding) begin
               failures++;
               $display("FAIL ack_spurious: ack_o toggled to %b with no complete token", ack_o);
            end
            outstanding = 1'b0;
            exp_q.push_back(cur_tok);
            ack_cnt++;
         end
         checks++;
         if (level !== 3'(exp_q.size()) || level > 3'(D)) begin
            failures++;
            $display("FAIL level_track: level=%0d expected %0d", level, exp_q.size());
         end
         checks++;
         if (vld_o !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL vld_track: vld_o=%b expected %b", vld_o, exp_q.size() != 0);
         end
         if (exp_q.size() == 0) begin
            checks++;
            if (dat_o !== '0) begin
               failures++;
               $display("FAIL dat_empty: dat_o=%b expected 0000", dat_o);
            end
         end else if (vld_o === 1'b1 && rdy_i === 1'b1) begin
            checks++;
            if (dat_o !== exp_q[0]) begin
               failures++;
               $display("FAIL pop_data: dat_o=%b expected %b", dat_o, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
      end
      ack_prev = ack_o;
   end

   always @(posedge clk) begin
      if (rand_rdy_en) begin
         #1;
         rdy_i = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic toggle_bit(input int i, input bit v);
      if (v) rails[i][1] = ~rails[i][1];
      else   rails[i][0] = ~rails[i][0];
   endtask

   task automatic start_token(input logic [W-1:0] w);
      cur_tok = w;
      for (int i = 0; i < W; i++) toggle_bit(i, w[i]);
      outstanding = 1'b1;
      prod_ph     = ~prod_ph;
   endtask

   task automatic wait_ack(input string name, input int budget);
      int n = 0;
      while (ack_o !== prod_ph && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (ack_o !== prod_ph) begin
         failures++;
         $display("FAIL %s: ack_o=%b expected %b within %0d cycles", name, ack_o, prod_ph, budget);
      end
   endtask

   task automatic send(input logic [W-1:0] w, input string name);
      tick();
      start_token(w);
      wait_ack(name, 400);
   endtask

   task automatic drain();
      int n = 0;
      tick();
      rdy_i = 1'b1;
      while (vld_o !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      tick();
      rdy_i = 1'b0;
      @(negedge clk);
      checks++;
      if (vld_o !== 1'b0 || level !== 3'd0) begin
         failures++;
         $display("FAIL drain: vld_o=%b level=%0d expected 0 and 0", vld_o, level);
      end
   endtask

   task automatic test_reset();
      rst   = 1'b0;
      rails = '0;
      rdy_i = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (ack_o !== 1'b0)  begin failures++; $display("FAIL reset_ack: ack_o=%b expected 0", ack_o); end
      checks++; if (vld_o !== 1'b0)  begin failures++; $display("FAIL reset_vld: vld_o=%b expected 0", vld_o); end
      checks++; if (level !== 3'd0)  begin failures++; $display("FAIL reset_level: level=%0d expected 0", level); end
      checks++; if (dat_o !== 4'd0)  begin failures++; $display("FAIL reset_dat: dat_o=%b expected 0000", dat_o); end
      @(posedge clk);
      #3 rst = 1'b1;
      tick();
      mon_en = 1'b1;
   endtask

   task automatic test_basic();
      int n = 0;
      tick();
      start_token(4'b0101);
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (vld_o !== 1'b1 && n < 20);
      checks++; if (n != S + 1)        begin failures++; $display("FAIL basic_latency: %0d cycles expected %0d", n, S + 1); end
      checks++; if (dat_o !== 4'b0101) begin failures++; $display("FAIL basic_dat: dat_o=%b expected 0101", dat_o); end
      checks++; if (ack_o !== 1'b1)    begin failures++; $display("FAIL basic_ack: ack_o=%b expected 1", ack_o); end
      checks++; if (level !== 3'd1)    begin failures++; $display("FAIL basic_level: level=%0d expected 1", level); end
   endtask

   task automatic test_second_and_pop();
      send(4'b1111, "second_ack");
      checks++; if (level !== 3'd2)    begin failures++; $display("FAIL second_level: level=%0d expected 2", level); end
      checks++; if (ack_o !== 1'b0)    begin failures++; $display("FAIL second_ack_lvl: ack_o=%b expected 0", ack_o); end
      checks++; if (dat_o !== 4'b0101) begin failures++; $display("FAIL pop1_dat: dat_o=%b expected 0101", dat_o); end
      tick(); rdy_i = 1'b1; tick(); rdy_i = 1'b0;
      @(negedge clk);
      checks++; if (dat_o !== 4'b1111) begin failures++; $display("FAIL pop2_dat: dat_o=%b expected 1111", dat_o); end
      tick(); rdy_i = 1'b1; tick(); rdy_i = 1'b0;
      @(negedge clk);
      checks++; if (vld_o !== 1'b0 || dat_o !== 4'd0) begin
         failures++; $display("FAIL pop_empty: vld_o=%b dat_o=%b expected 0 and 0000", vld_o, dat_o);
      end
   endtask

   task automatic test_partial();
      logic [W-1:0] w = 4'b0110;
      logic         ack0;
      int           n = 0;
      tick();
      cur_tok = w;
      for (int i = 0; i < 3; i++) toggle_bit(i, w[i]);
      ack0 = ack_o;
      repeat (20) @(negedge clk);
      checks++; if (ack_o !== ack0 || level !== 3'd0) begin
         failures++; $display("FAIL partial_hold: ack_o=%b level=%0d expected %b and 0", ack_o, level, ack0);
      end
      tick();
      toggle_bit(3, w[3]);
      outstanding = 1'b1;
      prod_ph     = ~prod_ph;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (vld_o !== 1'b1 && n < S + 1);
      checks++; if (vld_o !== 1'b1) begin failures++; $display("FAIL partial_complete: vld_o=%b expected 1 within %0d cycles", vld_o, S + 1); end
      checks++; if (dat_o !== w)    begin failures++; $display("FAIL partial_dat: dat_o=%b expected %b", dat_o, w); end
      drain();
   endtask

   task automatic test_stall();
      logic [W-1:0] toks[5];
      int           base;
      for (int k = 0; k < 5; k++) toks[k] = 4'($urandom);
      rdy_i = 1'b0;
      base  = ack_cnt;
      for (int k = 0; k < 4; k++) send(toks[k], "stall_fill_ack");
      tick();
      start_token(toks[4]);
      repeat (10) @(negedge clk);
      #1;
      checks++; if (level !== 3'd4)      begin failures++; $display("FAIL stall_level: level=%0d expected 4", level); end
      checks++; if (ack_cnt - base != 4) begin failures++; $display("FAIL stall_acks: %0d toggles expected 4", ack_cnt - base); end
      checks++; if (ack_o !== ~prod_ph)  begin failures++; $display("FAIL stall_ack_hold: ack_o=%b expected %b", ack_o, ~prod_ph); end
      tick(); rdy_i = 1'b1; tick(); rdy_i = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (level !== 3'd4)      begin failures++; $display("FAIL unstall_level: level=%0d expected 4", level); end
      checks++; if (ack_cnt - base != 5) begin failures++; $display("FAIL unstall_acks: %0d toggles expected 5", ack_cnt - base); end
      checks++; if (dat_o !== toks[1])   begin failures++; $display("FAIL unstall_head: dat_o=%b expected %b", dat_o, toks[1]); end
      drain();
   endtask

   task automatic test_reset_mid();
      rdy_i = 1'b0;
      for (int k = 0; k < 3; k++) send(4'($urandom), "midrst_fill_ack");
      tick();
      cur_tok = 4'b0011;
      toggle_bit(0, 1'b1);
      toggle_bit(1, 1'b1);
      repeat (3) tick();
      @(posedge clk);
      #2;
      mon_en = 1'b0;
      rst    = 1'b0;
      #1;
      checks++; if (vld_o !== 1'b0) begin failures++; $display("FAIL midrst_vld: vld_o=%b expected 0", vld_o); end
      checks++; if (level !== 3'd0) begin failures++; $display("FAIL midrst_level: level=%0d expected 0", level); end
      checks++; if (ack_o !== 1'b0) begin failures++; $display("FAIL midrst_ack: ack_o=%b expected 0", ack_o); end
      exp_q.delete();
      outstanding = 1'b0;
      prod_ph     = 1'b0;
      rails       = '0;
      repeat (3) tick();
      #2 rst = 1'b1;
      repeat (2) tick();
      mon_en = 1'b1;
      send(4'b1010, "midrst_new_ack");
      checks++; if (dat_o !== 4'b1010) begin failures++; $display("FAIL midrst_new_dat: dat_o=%b expected 1010", dat_o); end
      drain();
   endtask

   task automatic test_random();
      int           base = ack_cnt;
      int           order[W];
      logic [W-1:0] w;
      rand_rdy_en = 1'b1;
      for (int t = 0; t < 1000; t++) begin
         w = 4'($urandom);
         tick();
         if ($urandom_range(0, 1) == 0) begin
            start_token(w);
         end else begin
            // Rails arrive one bit at a time in a shuffled order with gaps.
            for (int i = 0; i < W; i++) order[i] = i;
            for (int i = W - 1; i > 0; i--) begin
               int j   = $urandom_range(0, i);
               int tmp = order[i];
               order[i] = order[j];
               order[j] = tmp;
            end
            cur_tok = w;
            for (int i = 0; i < W; i++) begin
               toggle_bit(order[i], w[order[i]]);
               if (i < W - 1 && $urandom_range(0, 1) == 1) tick();
            end
            outstanding = 1'b1;
            prod_ph     = ~prod_ph;
         end
         wait_ack("random_ack", 500);
      end
      rand_rdy_en = 1'b0;
      tick();
      drain();
      checks++; if (ack_cnt - base != 1000) begin failures++; $display("FAIL random_count: %0d tokens accepted expected 1000", ack_cnt - base); end
      checks++; if (exp_q.size() != 0)      begin failures++; $display("FAIL random_leftover: %0d words undelivered expected 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_second_and_pop();
      test_partial();
      test_stall();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tp_sync_sink.md
TP_SYNC_SINK -- requirements
Module: tp_sync_sink

Interface
REQ-001 Parameter WIDTH, default 32; data bits per token.
REQ-002 Parameter DEPTH, default 4; FIFO entries; SHALL be a power of two and at least 2.
REQ-003 Parameter SYNC_STAGES, default 2; flip-flop stages per rail synchronizer; minimum 2.
REQ-004 clk  input  1  sole clock; all state SHALL be clocked on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 in  input  [WIDTH-1:0][1:0]  two-phase dual-rail data; rail 1 toggles for value 1, rail 0 toggles for value 0; asynchronous to clk.
REQ-007 ack_o  output  1  two-phase acknowledge to the upstream producer; each toggle accepts one token.
REQ-008 dat_o  output  WIDTH  decoded data at the FIFO head.
REQ-009 vld_o  output  1  FIFO non-empty.
REQ-010 rdy_i  input  1  consumer ready; a pop SHALL occur on a cycle with vld_o=1 and rdy_i=1.
REQ-011 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-012 Every rail of in SHALL pass through its own SYNC_STAGES-flop synchronizer before any other logic uses it. No combinational path SHALL exist from in to any output.
REQ-013 State SHALL hold r0_q and r1_q, each WIDTH wide: the synchronized rails captured at the last accepted token. It SHALL also hold the 1-bit expected phase ph.
REQ-014 A token SHALL be complete when, for every bit i, (s1[i] XOR s0[i]) equals NOT ph, where s0 and s1 are the synchronizer outputs. A partially arrived token SHALL NOT be complete.
REQ-015 The decoded bit i SHALL be s1[i] XOR r1_q[i].
REQ-016 The FSM SHALL have two states, WAIT and STALL.
REQ-017 In WAIT, with the token complete and space available, the block SHALL in one cycle: push the decoded word, load r0_q/r1_q from s0/s1, invert ph, and toggle ack_o. The FSM SHALL remain in WAIT.
REQ-018 Space is available when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
REQ-019 In WAIT, with the token complete and no space, the FSM SHALL go to STALL. ack_o, ph, r0_q and r1_q SHALL hold.
REQ-020 In STALL, the push actions of REQ-017 SHALL be performed on the first cycle space is available, and the FSM SHALL return to WAIT.
REQ-021 ack_o SHALL toggle exactly once per accepted token and never otherwise.
REQ-022 Latency: from the last rail transition of a token to vld_o=1, with the FIFO empty, SHALL be SYNC_STAGES+1 cycles.
REQ-023 Throughput SHALL be at most one token per cycle.
REQ-024 FIFO SHALL be first-in first-out.
REQ-025 dat_o SHALL show the head entry whenever vld_o=1 and SHALL be 0 when the FIFO is empty.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH.
REQ-027 Simultaneous push and pop SHALL leave level unchanged.
REQ-028 A pop with vld_o=0 SHALL be ignored.
REQ-029 Overflow SHALL be impossible: no push without space.
REQ-030 Rail activity while a token is incomplete SHALL produce no push and no ack_o toggle.

Reset
REQ-031 With rst=0, the following SHALL be set asynchronously and held: ack_o=0, ph=0, r0_q=0, r1_q=0, synchronizers cleared, FIFO empty (level=0, vld_o=0, dat_o=0), FSM in WAIT.
REQ-032 A reset mid-token or in STALL SHALL discard all pending and buffered data.
REQ-033 The upstream link SHALL be restarted with all rails at 0, matching ph=0.
REQ-034 Deassertion of rst SHALL take effect at the next rising clk edge.

Verification
REQ-035 WIDTH=4, DEPTH=4. Toggle rail 1 of bits 0 and 2 and rail 0 of bits 1 and 3 -> after 3 cycles vld_o=1, dat_o=4'b0101, ack_o 0->1, level=1.
REQ-036 Send a second token 4'b1111 with no pop -> level=2 and ack_o returns to 0. Pop twice -> dat_o reads 4'b0101 then 4'b1111, then vld_o=0 and dat_o=0.
REQ-037 Toggle only 3 of 4 bits and hold for 20 cycles -> no push and ack_o constant. Toggle the 4th bit -> push occurs within SYNC_STAGES+1 cycles.
REQ-038 rdy_i=0, send 5 tokens -> level=4, FSM in STALL, ack_o toggled 4 times. Raise rdy_i for 1 cycle -> 5th token pushed in the same cycle, level stays 4, ack_o toggles a 5th time.
REQ-039 Assert rst with level=3 and a token half-arrived -> vld_o=0, level=0, ack_o=0 immediately. After release with rails zeroed, a new token 4'b1010 -> dat_o=4'b1010.
REQ-040 Stream 1000 random tokens with random rdy_i -> output sequence equals input sequence, no loss or duplication, level never exceeds DEPTH.
